// File: rtl/dds_pkg.sv
// Shared constants, types and parameter sanity helpers for the DDS phase path.
package dds_pkg;

  // 16-bit Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Default phase width shared with the downstream sine/cosine LUT.
  localparam int unsigned DDS_PHASE_DW = 16;
  typedef logic [DDS_PHASE_DW-1:0] phase_t;

  // The accumulator must carry fractional bits below the emitted phase.
  function automatic bit acc_wider_than_phase(input int acc_dw, input int phase_dw);
    return (acc_dw > phase_dw);
  endfunction

  // Dither must fit entirely below the truncation point and within the LFSR.
  function automatic bit dither_fits(input int acc_dw, input int phase_dw, input int dither_dw);
    return acc_wider_than_phase(acc_dw, phase_dw) &&
           (dither_dw > 0) &&
           (dither_dw <= int'(LFSR_W)) &&
           (dither_dw <= (acc_dw - phase_dw));
  endfunction

endpackage

// File: rtl/dds_lfsr.sv
// Free-running 16-bit Galois LFSR with enable; resets to a non-zero seed so
// it can never enter the all-zero lock-up state.
module dds_lfsr
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next state: shift right and fold the polynomial in when a one falls out.
  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = state_q >> 1;
      if (state_q[0]) begin
        state_d = state_d ^ LFSR_POLY;
      end
    end
  end

  // State register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/dds_phase_accumulator.sv
// NCO phase generator: rate divider, FTW accumulator with a one-deep update
// slot, phase offset, optional sub-LSB dither, truncated valid-only output.
module dds_phase_accumulator
  import dds_pkg::*;
#(
  parameter int PHASE_DW   = 16,
  parameter int ACC_DW     = 32,
  parameter int RATE_DW    = 8,
  parameter int USE_DITHER = 0,
  parameter int DITHER_DW  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [RATE_DW-1:0]  rate,
  input  logic [ACC_DW-1:0]   s_axis_ftw_tdata,
  input  logic                s_axis_ftw_tvalid,
  output logic                s_axis_ftw_tready,
  input  logic [PHASE_DW-1:0] s_axis_poff_tdata,
  input  logic                s_axis_poff_tvalid,
  input  logic                sync,
  output logic [PHASE_DW-1:0] m_axis_phase_tdata,
  output logic                m_axis_phase_tvalid
);

  // Dither is only wired in when the widths leave room for it.
  localparam bit DITHER_EN    = (USE_DITHER != 0) && dither_fits(ACC_DW, PHASE_DW, DITHER_DW);
  localparam int DITHER_SHIFT = ACC_DW - PHASE_DW - DITHER_DW;

  logic [RATE_DW-1:0]  cnt_q, cnt_d;
  logic [ACC_DW-1:0]   acc_q, acc_d;
  logic [ACC_DW-1:0]   ftw_active_q, ftw_active_d;
  logic [ACC_DW-1:0]   ftw_next_q, ftw_next_d;
  logic                ftw_pending_q, ftw_pending_d;
  logic [PHASE_DW-1:0] poff_q, poff_d;
  logic [PHASE_DW-1:0] phase_q, phase_d;
  logic                valid_q, valid_d;

  logic                strobe;
  logic                ftw_hs;
  logic                lfsr_en;
  logic [LFSR_W-1:0]   lfsr_state;
  logic [ACC_DW-1:0]   dither_add;
  logic [ACC_DW-1:0]   phase_sum;
  logic [PHASE_DW-1:0] phase_trunc;
  logic                unused_bits;

  // A sample is due once the divider reaches rate; sync suppresses it.
  assign strobe  = (cnt_q >= rate) && !sync;
  assign ftw_hs  = s_axis_ftw_tvalid && !ftw_pending_q;
  assign lfsr_en = strobe && DITHER_EN;

  dds_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (lfsr_en),
    .state_o (lfsr_state)
  );

  if (DITHER_EN) begin : g_dither
    assign dither_add = {{(ACC_DW-DITHER_DW){1'b0}}, lfsr_state[DITHER_DW-1:0]} << DITHER_SHIFT;
  end else begin : g_no_dither
    assign dither_add = '0;
  end

  // Truncation drops the fractional bits; dither perturbs them beforehand.
  assign phase_sum   = acc_q + dither_add;
  assign phase_trunc = phase_sum[ACC_DW-1 -: PHASE_DW];
  assign unused_bits = ^{lfsr_state, phase_sum[ACC_DW-PHASE_DW-1:0]};

  // Rate divider: restart on every strobe and on sync.
  always_comb begin
    cnt_d = cnt_q + RATE_DW'(1);
    if (strobe || sync) begin
      cnt_d = '0;
    end
  end

  // Accumulator, FTW update slot and offset register.
  always_comb begin
    acc_d         = acc_q;
    ftw_active_d  = ftw_active_q;
    ftw_next_d    = ftw_next_q;
    ftw_pending_d = ftw_pending_q;
    poff_d        = poff_q;
    if (sync) begin
      acc_d = '0;
    end else if (strobe) begin
      // The strobe that promotes a queued FTW still steps with the old one.
      acc_d = acc_q + ftw_active_q;
    end
    if (strobe && ftw_pending_q) begin
      ftw_active_d  = ftw_next_q;
      ftw_pending_d = 1'b0;
    end
    if (ftw_hs) begin
      ftw_next_d    = s_axis_ftw_tdata;
      ftw_pending_d = 1'b1;
    end
    if (s_axis_poff_tvalid) begin
      poff_d = s_axis_poff_tdata;
    end
  end

  // Output stage: pre-increment phase plus offset, held between strobes.
  always_comb begin
    valid_d = strobe;
    phase_d = phase_q;
    if (strobe) begin
      phase_d = phase_trunc + poff_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      ftw_active_q  <= '0;
      ftw_next_q    <= '0;
      ftw_pending_q <= 1'b0;
      poff_q        <= '0;
      phase_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      ftw_active_q  <= ftw_active_d;
      ftw_next_q    <= ftw_next_d;
      ftw_pending_q <= ftw_pending_d;
      poff_q        <= poff_d;
      phase_q       <= phase_d;
      valid_q       <= valid_d;
    end
  end

  assign s_axis_ftw_tready   = !ftw_pending_q;
  assign m_axis_phase_tdata  = phase_q;
  assign m_axis_phase_tvalid = valid_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Bench for dds_phase_accumulator: a plain and a dithered instance share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_dds_phase_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rate;
  logic [31:0] ftw_tdata;
  logic        ftw_tvalid;
  logic [15:0] poff_tdata;
  logic        poff_tvalid;
  logic        sync;

  logic        ftw_tready, ftw_tready_d;
  logic [15:0] ph, ph_d;
  logic        ph_v, ph_v_d;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int unsigned m_cnt;
  bit [31:0]   m_acc;
  bit [31:0]   m_ftw;
  bit [31:0]   ftw_q[$];
  bit [15:0]   m_poff;
  bit [15:0]   m_lfsr;
  bit          e_valid;
  bit [15:0]   e_data;
  bit [15:0]   e_data_d;

  always #5 clk = ~clk;

  dds_phase_accumulator #(
    .PHASE_DW(16), .ACC_DW(32), .RATE_DW(8), .USE_DITHER(0), .DITHER_DW(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rate(rate),
    .s_axis_ftw_tdata(ftw_tdata), .s_axis_ftw_tvalid(ftw_tvalid), .s_axis_ftw_tready(ftw_tready),
    .s_axis_poff_tdata(poff_tdata), .s_axis_poff_tvalid(poff_tvalid), .sync(sync),
    .m_axis_phase_tdata(ph), .m_axis_phase_tvalid(ph_v)
  );

  dds_phase_accumulator #(
    .PHASE_DW(16), .ACC_DW(32), .RATE_DW(8), .USE_DITHER(1), .DITHER_DW(4)
  ) dut_d (
    .clk(clk), .reset_n(reset_n), .rate(rate),
    .s_axis_ftw_tdata(ftw_tdata), .s_axis_ftw_tvalid(ftw_tvalid), .s_axis_ftw_tready(ftw_tready_d),
    .s_axis_poff_tdata(poff_tdata), .s_axis_poff_tvalid(poff_tvalid), .sync(sync),
    .m_axis_phase_tdata(ph_d), .m_axis_phase_tvalid(ph_v_d)
  );

  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit [15:0] top16(input bit [31:0] x);
    return x[31:16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_ftw = 0; ftw_q.delete();
    m_poff = 0; m_lfsr = 16'hACE1; e_valid = 0; e_data = 0; e_data_d = 0;
  endtask

  // Advance the model on the current inputs, clock once, compare all outputs.
  task automatic step();
    bit strobe, hs;
    bit [31:0] d;
    if (!reset_n) begin
      model_reset();
    end else begin
      strobe  = !sync && (m_cnt >= 32'(rate));
      hs      = ftw_tvalid && (ftw_q.size() == 0);
      e_valid = strobe;
      if (strobe) begin
        d        = {28'b0, m_lfsr[3:0]} << 12;
        e_data   = top16(m_acc) + m_poff;
        e_data_d = top16(m_acc + d) + m_poff;
        m_lfsr   = lfsr_next(m_lfsr);
        m_acc    = m_acc + m_ftw;
        if (ftw_q.size() != 0) m_ftw = ftw_q.pop_front();
      end
      if (hs) ftw_q.push_back(ftw_tdata);
      if (sync || strobe) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (sync) m_acc = 0;
      if (poff_tvalid) m_poff = poff_tdata;
    end
    @(posedge clk);
    #1;
    chk("tvalid", 32'(ph_v), 32'(e_valid));
    chk("tdata", 32'(ph), 32'(e_data));
    chk("tready", 32'(ftw_tready), 32'(ftw_q.size() == 0));
    chk("tvalid_dither", 32'(ph_v_d), 32'(e_valid));
    chk("tdata_dither", 32'(ph_d), 32'(e_data_d));
  endtask

  // Offer an FTW and hold it until accepted, with a bounded wait.
  task automatic send_ftw(input bit [31:0] v);
    bit took;
    took = 0;
    ftw_tdata  = v;
    ftw_tvalid = 1'b1;
    for (int i = 0; i < 600 && !took; i++) begin
      took = ftw_tready;
      step();
    end
    ftw_tvalid = 1'b0;
    chk("ftw_accept_in_time", 32'(took), 32'd1);
  endtask

  task automatic wait_valid(input string tag, output int n);
    bit seen;
    seen = 0;
    n = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      n++;
      seen = ph_v;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bit [15:0] prev;
    bit [15:0] err;
    int n;
    int err_sum;
    int samples;

    reset_n = 0; rate = 0; ftw_tdata = 0; ftw_tvalid = 0;
    poff_tdata = 0; poff_tvalid = 0; sync = 0;
    model_reset();
    repeat (3) step();
    chk("reset_tdata", 32'(ph), 32'h0);
    chk("reset_tready", 32'(ftw_tready), 32'd1);

    // rate=0 ramp with FTW 0x0100_0000
    reset_n = 1;
    send_ftw(32'h0100_0000);
    repeat (6) step();
    prev = ph;
    step();
    chk("ramp_delta_0100", 32'(ph - prev), 32'h0100);
    chk("ramp_every_cycle", 32'(ph_v), 32'd1);

    // rate=3: period of 4, step of 0x0400
    rate = 3;
    send_ftw(32'h0400_0000);
    repeat (12) step();
    wait_valid("rate3_first_valid", n);
    for (int k = 0; k < 3; k++) begin
      prev = ph;
      wait_valid("rate3_valid", n);
      chk("rate3_period", 32'(n), 32'd4);
      chk("rate3_delta", 32'(ph - prev), 32'h0400);
    end

    // rate drop below the running count must strobe on the next cycle
    rate = 7;
    for (int i = 0; i < 20 && m_cnt != 5; i++) step();
    chk("cnt_reached_5", m_cnt, 32'd5);
    rate = 2;
    step();
    chk("rate_drop_strobe", 32'(ph_v), 32'd1);
    repeat (10) step();

    // half-cycle FTW: wrap, then with a quarter-turn offset
    rate = 0;
    send_ftw(32'h8000_0000);
    repeat (3) step();
    sync = 1; step(); sync = 0;
    repeat (2) step();
    prev = ph;
    step();
    chk("wrap_alternate", 32'(ph), 32'(prev ^ 16'h8000));
    poff_tdata = 16'h4000; poff_tvalid = 1; step(); poff_tvalid = 0;
    step();
    chk("poff_alt_values", 32'(ph == 16'h4000 || ph == 16'hC000), 32'd1);
    prev = ph;
    step();
    chk("poff_alternate", 32'(ph), 32'(prev ^ 16'h8000));

    // FTW stress: second offer while one is pending is held off
    rate = 3;
    ftw_tdata = 32'h0010_0000; ftw_tvalid = 1;
    for (int i = 0; i < 10 && !ftw_tready; i++) step();
    step();
    ftw_tdata = 32'h0020_0000;
    chk("tready_low_while_pending", 32'(ftw_tready), 32'd0);
    step();
    chk("tready_still_low", 32'(ftw_tready), 32'(ftw_q.size() == 0));
    send_ftw(32'h0020_0000);
    repeat (20) step();

    // sync mid-run
    rate = 1;
    repeat (6) step();
    sync = 1; step(); sync = 0;
    chk("sync_no_valid", 32'(ph_v), 32'd0);
    wait_valid("post_sync_valid", n);
    chk("post_sync_phase_is_poff", 32'(ph), 32'(m_poff));

    // reset pulse mid-run discards everything
    ftw_tdata = 32'h1234_5678; ftw_tvalid = 1; step(); ftw_tvalid = 0;
    reset_n = 0; step(); reset_n = 1;
    chk("midreset_tdata", 32'(ph), 32'h0);
    chk("midreset_tvalid", 32'(ph_v), 32'd0);
    chk("midreset_tready", 32'(ftw_tready), 32'd1);
    repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) rate = 8'($urandom_range(0, 5));
      ftw_tvalid  = ($urandom_range(0, 3) == 0);
      ftw_tdata   = $urandom;
      poff_tvalid = ($urandom_range(0, 7) == 0);
      poff_tdata  = 16'($urandom);
      sync        = ($urandom_range(0, 39) == 0);
      reset_n     = ($urandom_range(0, 499) != 0);
      step();
    end
    ftw_tvalid = 0; poff_tvalid = 0; sync = 0; reset_n = 1;

    // dither statistics against the undithered reference
    reset_n = 0; step(); reset_n = 1;
    rate = 0;
    send_ftw(32'h0001_0000);
    err_sum = 0;
    samples = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      chk("lfsr_nonzero", 32'(dut_d.lfsr_state != 16'h0), 32'd1);
      if (e_valid) begin
        err = ph_d - e_data;
        chk("dither_within_1lsb", 32'(err == 16'h0 || err == 16'h1 || err == 16'hFFFF), 32'd1);
        if (err == 16'h1) err_sum++;
        else if (err == 16'hFFFF) err_sum--;
        samples++;
      end
    end
    chk("dither_samples", 32'(samples >= 4000), 32'd1);
    chk("dither_mean_lt_half", 32'((2 * (err_sum < 0 ? -err_sum : err_sum)) < samples), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_phase_accumulator.md
Name: dds_phase_accumulator

Overview:
Numerically controlled phase generator that sits directly upstream of the dds sine/cosine LUT stage. It accumulates a frequency tuning word (FTW) at a programmable sample rate. It adds a phase offset and optional LFSR dither, then emits a truncated PHASE_DW-bit phase on an AXI-Stream-style valid-only output. That output is meant to connect directly to the dds s_axis_phase_tdata/tvalid inputs.

Parameters:
PHASE_DW, 16, output phase width; must match the downstream dds PHASE_DW
ACC_DW, 32, accumulator and FTW width; must satisfy ACC_DW > PHASE_DW
RATE_DW, 8, width of the rate-divider setting
USE_DITHER, 0, 1 = add LFSR dither below the truncation point
DITHER_DW, 4, number of dither bits; must satisfy DITHER_DW <= ACC_DW-PHASE_DW

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
rate  in  RATE_DW  output strobe every rate+1 cycles; quasi-static
s_axis_ftw_tdata  in  ACC_DW  new tuning word
s_axis_ftw_tvalid  in  1  tuning word valid
s_axis_ftw_tready  out  1  high when no FTW update is pending
s_axis_poff_tdata  in  PHASE_DW  phase offset
s_axis_poff_tvalid  in  1  offset valid; no ready, always accepted
sync  in  1  phase-reset request
m_axis_phase_tdata  out  PHASE_DW  phase to dds
m_axis_phase_tvalid  out  1  phase valid, single-cycle pulse per sample

Behaviour:
- Clock and reset: single clock clk. reset_n is synchronous and active-low, sampled on posedge clk.
- Reset values: cnt=0, acc=0, ftw_active=0, ftw_pending=0, ftw_next=0, poff_q=0, lfsr=16'hACE1, m_axis_phase_tdata=0, m_axis_phase_tvalid=0.
- Reset output levels: s_axis_ftw_tready=1 (combinational !ftw_pending).
- Rate divider:
  - strobe = (cnt >= rate) && !sync.
  - On strobe: cnt<=0. Otherwise: cnt<=cnt+1.
  - Using >= means a rate decrease below the current cnt wraps on the next cycle; the counter never runs away.
  - rate=0 gives a strobe every cycle.
- Accumulator: on strobe, acc <= acc + ftw_active, mod 2^ACC_DW. Natural wrap; no saturation.
- Output, 1-cycle latency after strobe:
  - m_axis_phase_tvalid <= strobe.
  - On strobe, m_axis_phase_tdata <= (trunc(acc + d) + poff_q) mod 2^PHASE_DW.
  - acc here is the pre-increment value, so the first sample after reset or sync equals poff_q.
  - trunc(x) = x[ACC_DW-1 -: PHASE_DW].
  - d = USE_DITHER ? lfsr[DITHER_DW-1:0] << (ACC_DW-PHASE_DW-DITHER_DW) : 0.
  - Between strobes, tdata holds its value.
- Dither LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances once per strobe, only when USE_DITHER=1.
  - Never reaches zero state.
- FTW handshake:
  - Handshake = tvalid && tready. On handshake: ftw_next<=tdata, ftw_pending<=1.
  - On a strobe with ftw_pending=1: ftw_active<=ftw_next, ftw_pending<=0.
  - That strobe still increments acc with the old ftw_active. The new FTW takes effect from the following strobe.
  - A handshake on a strobe cycle while not pending is captured and applied at the next strobe.
  - Only one update can be queued; tready stays low until it is applied.
- Offset: when s_axis_poff_tvalid=1, poff_q<=tdata, effective for the next strobe. Last write in a cycle wins.
- Sync:
  - In a sync cycle: acc<=0, cnt<=0, no strobe, m_axis_phase_tvalid<=0.
  - ftw_active, ftw_pending and poff_q are unaffected.
  - The LFSR is not reseeded.
  - The first post-sync strobe occurs when cnt reaches rate.
- Reset mid-operation: all state returns to reset values in the same clock edge. Any pending FTW is discarded.

Decomposition:
- Package dds_pkg:
  - LFSR polynomial constant 16'hB400 (Galois mask) and seed 16'hACE1.
  - Width-check helper functions.
  - Shared phase typedef sized by PHASE_DW (default 16).
- Sub-module dds_lfsr: 16-bit Galois LFSR with enable, synchronous active-low reset to seed, parallel output.
- Accumulator, divider and handshake logic live in the top block.

Test Plan:
- Reset, rate=0, FTW=32'h0100_0000, poff=0, no dither -> tvalid every cycle; phase 16'h0000, 16'h0100, 16'h0200, ... (the first sample still reflects FTW=0, i.e. 0, 0, 0x0100 ...); tready returns high after the first strobe.
- rate=3, FTW=32'h0400_0000 -> tvalid pulses exactly every 4 cycles; consecutive phases differ by 16'h0400; rate changed from 7 to 2 while cnt=5 -> strobe on the next cycle, no lockup.
- FTW=32'h8000_0000 -> phase alternates 16'h0000/16'h8000, verifying wrap. With poff=16'h4000 -> alternates 16'h4000/16'hC000.
- FTW update stress: second tvalid while pending -> tready=0 and the value is held off; first update applied exactly at the next strobe; phase step changes one sample later.
- sync asserted mid-run (rate=1) -> no tvalid in the sync cycle; next sample equals poff_q; FTW unchanged; reset_n low for 1 cycle mid-run -> all outputs 0, tready=1.
- USE_DITHER=1, FTW=32'h0001_0000, 4096 samples -> every output within ±1 LSB of the undithered reference; mean error < 0.5 LSB; LFSR never zero.
